// File: rtl/hilo_div_unit.sv
// ---------------------------------------------------------------------------
// hilo_div_unit
//
// Architectural HI/LO register pair with a 32-step restoring divider.
// HI/LO accept single-cycle writes from the ALU path (MTHI/MTLO/MULT/MULTU)
// and receive the DIV/DIVU result (LO = quotient, HI = remainder) one edge
// after the divider reaches DONE. The busy/done pair feeds the stall logic.
//
// Ports:
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   hi_we       HI write strobe from the ALU path
//   lo_we       LO write strobe from the ALU path
//   hi_wdata    HI write data
//   lo_wdata    LO write data
//   div_start   start a divide (only honoured in IDLE)
//   div_signed  1 = DIV (two's complement), 0 = DIVU
//   div_a       dividend, sampled with div_start
//   div_b       divisor, sampled with div_start
//   div_cancel  abort an in-flight divide; beats div_start in IDLE
//   div_busy    high while in CALC or DONE
//   div_done    high for the single DONE cycle
//   hi_o        registered HI
//   lo_o        registered LO
// ---------------------------------------------------------------------------
module hilo_div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        div_cancel,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [5:0]  cnt_r;      // 6 bits so the count never wraps inside CALC
  logic [31:0] a_lat_r;    // raw dividend, needed for the divide-by-zero HI
  logic [31:0] dvsr_r;     // divisor magnitude
  logic [31:0] quot_r;     // dividend magnitude shifting out, quotient in
  logic [31:0] rem_r;      // partial remainder, always < dvsr_r
  logic        neg_q_r;
  logic        neg_r_r;
  logic        divz_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [32:0] diff_s;
  logic [31:0] rem_step_s;
  logic        q_bit_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  // Two's complement negation of a 32-bit value.
  function automatic logic [31:0] neg32(input logic [31:0] val);
    return (~val) + 32'd1;
  endfunction

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [31:0] mag32(input logic [31:0] val, input logic sgn);
    logic [31:0] res;
    if (sgn && val[31]) begin
      res = neg32(val);
    end else begin
      res = val;
    end
    return res;
  endfunction

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    diff_s     = {rem_r, quot_r[31]} - {1'b0, dvsr_r};
    rem_step_s = 32'd0;
    q_bit_s    = 1'b0;
    if (diff_s[32]) begin
      // Trial went negative: restore (keep the shifted remainder).
      rem_step_s = {rem_r[30:0], quot_r[31]};
      q_bit_s    = 1'b0;
    end else begin
      rem_step_s = diff_s[31:0];
      q_bit_s    = 1'b1;
    end
  end

  // Final result with sign fix-up, or the fixed divide-by-zero pattern.
  always_comb begin
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    if (divz_r) begin
      res_lo_s = 32'hFFFF_FFFF;
      res_hi_s = a_lat_r;
    end else begin
      if (neg_q_r) begin
        res_lo_s = neg32(quot_r);
      end else begin
        res_lo_s = quot_r;
      end
      if (neg_r_r) begin
        res_hi_s = neg32(rem_r);
      end else begin
        res_hi_s = rem_r;
      end
    end
  end

  // Divider FSM: operand latch, iteration, registered busy/done flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      a_lat_r <= 32'd0;
      dvsr_r  <= 32'd0;
      quot_r  <= 32'd0;
      rem_r   <= 32'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      divz_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (div_start && !div_cancel) begin
            state_r <= ST_CALC;
            cnt_r   <= 6'd0;
            a_lat_r <= div_a;
            dvsr_r  <= mag32(div_b, div_signed);
            quot_r  <= mag32(div_a, div_signed);
            rem_r   <= 32'd0;
            // Quotient negative when signs differ; remainder follows dividend.
            neg_q_r <= div_signed & (div_a[31] ^ div_b[31]);
            neg_r_r <= div_signed & div_a[31];
            divz_r  <= (div_b == 32'd0);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_CALC: begin
          if (div_cancel) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            quot_r <= {quot_r[30:0], q_bit_s};
            rem_r  <= rem_step_s;
            cnt_r  <= cnt_r + 6'd1;
            busy_r <= 1'b1;
            if (cnt_r == 6'd31) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_CALC;
              done_r  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          // Result write happens in the HI/LO block on this same edge.
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // HI/LO registers: divider result in an uncancelled DONE, else ALU writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if ((state_r == ST_DONE) && !div_cancel) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else begin
      if (hi_we) begin
        hi_r <= hi_wdata;
      end
      if (lo_we) begin
        lo_r <= lo_wdata;
      end
    end
  end

  assign div_busy = busy_r;
  assign div_done = done_r;
  assign hi_o     = hi_r;
  assign lo_o     = lo_r;

endmodule

// File: tb/tb_hilo_div_unit.sv
module tb_hilo_div_unit;

  logic        clk;
  logic        resetn;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_cancel;
  logic        div_busy;
  logic        div_done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks_cnt;
  int errors_cnt;

  hilo_div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hi_wdata   (hi_wdata),
    .lo_wdata   (lo_wdata),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_cancel (div_cancel),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
    hi_we = 1'b1; lo_we = 1'b1; hi_wdata = hv; lo_wdata = lv;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Present a start for one edge (E0); returns just after E0.
  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_start = 1'b1; div_signed = sgn; div_a = a; div_b = b;
    step();
    div_start = 1'b0;
  endtask

  // Step until div_done rises (bounded); n = edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (!div_done && n < 40) begin
      step();
      n++;
    end
  endtask

  // Full divide: 32 edges to DONE, one more to write HI/LO.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int n;
    start_div(sgn, a, b);
    check_eq({tag, "_busy_e0"}, {31'd0, div_busy}, 32'd1);
    wait_done(n);
    check_eq({tag, "_done_latency"}, n, 32'd32);
    step();
    check_eq({tag, "_done_clear"}, {31'd0, div_done}, 32'd0);
    check_eq({tag, "_busy_clear"}, {31'd0, div_busy}, 32'd0);
    check_eq({tag, "_lo"}, lo_o, exp_lo);
    check_eq({tag, "_hi"}, hi_o, exp_hi);
  endtask

  initial begin
    int n;
    checks_cnt = 0;
    errors_cnt = 0;
    resetn = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hi_wdata = 32'd0; lo_wdata = 32'd0;
    div_start = 1'b0; div_signed = 1'b0; div_a = 32'd0; div_b = 32'd0; div_cancel = 1'b0;
    #12;
    resetn = 1'b1;
    check_eq("rst_hi", hi_o, 32'd0);
    check_eq("rst_lo", lo_o, 32'd0);
    check_eq("rst_busy", {31'd0, div_busy}, 32'd0);
    check_eq("rst_done", {31'd0, div_done}, 32'd0);
    step();

    // External writes, 1-cycle latency
    write_hilo(32'h1234_5678, 32'h9ABC_DEF0);
    check_eq("wr_hi", hi_o, 32'h1234_5678);
    check_eq("wr_lo", lo_o, 32'h9ABC_DEF0);
    check_eq("wr_busy", {31'd0, div_busy}, 32'd0);
    // Independent strobe: only LO
    lo_we = 1'b1; lo_wdata = 32'h0000_0055;
    step();
    lo_we = 1'b0;
    check_eq("wr_lo_only_lo", lo_o, 32'h0000_0055);
    check_eq("wr_lo_only_hi", hi_o, 32'h1234_5678);

    // Back-to-back divides
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    run_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);

    // Cancel mid-CALC leaves preloaded HI/LO
    write_hilo(32'hAAAA_0000, 32'hAAAA_0000);
    start_div(1'b0, 32'd100, 32'd7);
    repeat (9) step();
    div_cancel = 1'b1;
    step();
    div_cancel = 1'b0;
    check_eq("cancel_busy", {31'd0, div_busy}, 32'd0);
    repeat (40) step();
    check_eq("cancel_hi", hi_o, 32'hAAAA_0000);
    check_eq("cancel_lo", lo_o, 32'hAAAA_0000);
    check_eq("cancel_done", {31'd0, div_done}, 32'd0);

    // Async reset mid-divide
    start_div(1'b0, 32'd100, 32'd7);
    repeat (19) step();
    resetn = 1'b0;
    #1;
    check_eq("arst_hi", hi_o, 32'd0);
    check_eq("arst_lo", lo_o, 32'd0);
    check_eq("arst_busy", {31'd0, div_busy}, 32'd0);
    #3;
    resetn = 1'b1;
    repeat (40) step();
    check_eq("arst_after_lo", lo_o, 32'd0);
    check_eq("arst_after_busy", {31'd0, div_busy}, 32'd0);

    // Start re-asserted mid-CALC with new operands is ignored
    write_hilo(32'hAAAA_0000, 32'hAAAA_0000);
    start_div(1'b0, 32'd100, 32'd7);
    repeat (5) step();
    div_start = 1'b1; div_signed = 1'b1; div_a = 32'd1000; div_b = 32'd3;
    step();
    div_start = 1'b0;
    wait_done(n);
    check_eq("restart_latency", n, 32'd26);
    step();
    check_eq("restart_lo", lo_o, 32'd14);
    check_eq("restart_hi", hi_o, 32'd2);
    step();
    check_eq("restart_not_queued", {31'd0, div_busy}, 32'd0);

    // External write in DONE is dropped
    write_hilo(32'hAAAA_0000, 32'hAAAA_0000);
    start_div(1'b0, 32'd100, 32'd7);
    wait_done(n);
    hi_we = 1'b1; hi_wdata = 32'hDEAD_BEEF; lo_we = 1'b1; lo_wdata = 32'hDEAD_BEEF;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    check_eq("done_wr_hi", hi_o, 32'd2);
    check_eq("done_wr_lo", lo_o, 32'd14);

    // Cancel in DONE: external write wins, no divider result
    start_div(1'b0, 32'd100, 32'd7);
    wait_done(n);
    div_cancel = 1'b1;
    hi_we = 1'b1; hi_wdata = 32'h1111_1111; lo_we = 1'b1; lo_wdata = 32'h2222_2222;
    step();
    div_cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check_eq("done_cancel_hi", hi_o, 32'h1111_1111);
    check_eq("done_cancel_lo", lo_o, 32'h2222_2222);
    check_eq("done_cancel_busy", {31'd0, div_busy}, 32'd0);

    // External write during CALC lands; cancel beats start in IDLE
    start_div(1'b0, 32'd9, 32'd3);
    hi_we = 1'b1; hi_wdata = 32'h0BAD_F00D;
    step();
    hi_we = 1'b0;
    check_eq("calc_wr_hi", hi_o, 32'h0BAD_F00D);
    wait_done(n);
    step();
    check_eq("calc_wr_res_lo", lo_o, 32'd3);
    check_eq("calc_wr_res_hi", hi_o, 32'd0);
    div_start = 1'b1; div_cancel = 1'b1; div_a = 32'd50; div_b = 32'd5;
    step();
    div_start = 1'b0; div_cancel = 1'b0;
    check_eq("cancel_vs_start_busy", {31'd0, div_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
# hilo_div_unit

HI/LO register pair plus a 32-cycle iterative divider, sitting beside the execute-stage ALU. It holds the architectural HI and LO registers and drives the values the ALU reads for MFHI/MFLO. It accepts single-cycle HI/LO writes from the ALU path (MTHI/MTLO/MULT/MULTU results) and executes DIV/DIVU as a multi-cycle operation, with a busy/done handshake that the pipeline stall logic consumes.

## Interface

Parameters:
- none (datapath fixed at 32 bits, iteration count fixed at 32)

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- hi_we  in  1  write strobe for HI from the ALU path
- lo_we  in  1  write strobe for LO from the ALU path
- hi_wdata  in  32  HI write data
- lo_wdata  in  32  LO write data
- div_start  in  1  start a divide; sampled only in IDLE
- div_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with div_start
- div_a  in  32  dividend; sampled with div_start
- div_b  in  32  divisor; sampled with div_start
- div_cancel  in  1  abort an in-flight divide (exception or flush)
- div_busy  out  1  high in CALC and DONE
- div_done  out  1  high for exactly the DONE cycle
- hi_o  out  32  registered HI value
- lo_o  out  32  registered LO value

## Operation

- Reset (resetn low, asynchronous): HI=0, LO=0, state IDLE, iteration counter=0, internal operands cleared. div_busy=0 and div_done=0 immediately.
- States: IDLE, CALC, DONE.
  - IDLE: if div_start && !div_cancel -> latch operands, go to CALC, counter=0.
  - CALC: one restoring shift-subtract step per edge on operand magnitudes; counter increments; after the 32nd step go to DONE.
  - DONE: on the next edge write quotient to LO and remainder to HI, go to IDLE.
  - div_cancel in CALC or DONE -> IDLE on the next edge; no HI/LO write from the divider.
- Signed handling (div_signed=1): divide the absolute values. Negate the quotient if the sign bits of a and b differ. The remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (div_b=0, either mode): runs the full 32 steps, then writes LO=0xFFFFFFFF and HI=div_a as latched, with no sign fix-up.
- Operands are latched at start. Later changes to div_a, div_b or div_signed have no effect on the divide in flight.
- div_start while busy is ignored. It is not queued.
- External writes:
  - hi_we and lo_we act on the next edge in IDLE and CALC, independently of each other.
  - In DONE the divider write has priority and a same-cycle external write is dropped.
  - If div_cancel is asserted in DONE, the external write takes effect instead.
- hi_o and lo_o come straight from the registers. There is no write-through bypass; forwarding is handled outside this block.

## Timing

- Start sampled at edge E0. CALC runs across E1..E32, and DONE is entered at E32.
- div_done is high between E32 and E33. HI/LO hold the result after E33, i.e. 33 cycles after E0.
- div_busy is high from after E0 until after E33.
- Back-to-back: a new div_start is accepted in the first IDLE cycle after E33.
- External HI/LO writes have 1-cycle latency: data visible on hi_o/lo_o after the capturing edge.
- div_cancel has priority over div_start in the same cycle. It takes effect at the next edge, so div_busy falls after that edge.
- Reset asserted mid-divide clears everything asynchronously, with no partial result written.
- The iteration counter is 6 bits, so it does not wrap during CALC.

## Test plan

- Reset, then hi_we=1/hi_wdata=0x12345678 and lo_we=1/lo_wdata=0x9ABCDEF0 for one cycle -> hi_o/lo_o show those values the next cycle, div_busy stays 0.
- DIVU 100/7 -> div_busy high 33 cycles, div_done one cycle, then LO=14, HI=2.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- Start DIVU 100/7 with HI=LO=0xAAAA0000 preloaded:
  - div_cancel at cycle 10 -> IDLE next edge, HI/LO unchanged.
  - Restart, pulse resetn low at cycle 20 -> HI=LO=0, div_busy=0 immediately.
  - Restart, div_start re-asserted with different operands mid-CALC -> ignored, result still 14/2.
  - Restart, hi_we during DONE -> divider result wins.
